// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// One quotient bit per cycle, fixed WIDTH-cycle latency, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operation, div_ready=1
// CALC  | one restoring step per cycle, WIDTH steps total
// DONE  | result held stable until res_ready, res_valid=1
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] div_result,
  output logic [WIDTH-1:0] mod_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] src1_raw;
  logic             div_zero;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;
  logic [WIDTH:0]   part;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;
  logic             last_step;

  assign div_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = div_valid & div_ready & ~div_flush;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    src1_abs = (div_signed & div_src1[WIDTH-1]) ? -div_src1 : div_src1;
    src2_abs = (div_signed & div_src2[WIDTH-1]) ? -div_src2 : div_src2;
  end

  // The shifted partial remainder is one bit wider than the divisor; the extra
  // top bit of diff is the borrow that decides restore vs. keep.
  always_comb begin
    part    = {rem, quo[WIDTH-1]};
    diff    = {1'b0, part} - {2'b00, divisor};
    ge      = ~diff[WIDTH+1];
    rem_nxt = ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      src1_raw   <= '0;
      div_zero   <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      div_result <= '0;
      mod_result <= '0;
    end else if (div_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= CALC;
            cnt      <= '0;
            quo      <= src1_abs;
            rem      <= '0;
            divisor  <= src2_abs;
            src1_raw <= div_src1;
            div_zero <= (div_src2 == '0);
            sign_q   <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
            sign_r   <= div_signed & div_src1[WIDTH-1];
          end
        end
        CALC: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            state <= DONE;
            // Divide-by-zero bypasses the sign fix so the dividend comes back untouched.
            if (div_zero) begin
              div_result <= '1;
              mod_result <= src1_raw;
            end else begin
              div_result <= sign_q ? -quo_nxt : quo_nxt;
              mod_result <= sign_r ? -rem_nxt : rem_nxt;
            end
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
